// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one 32-bit schedule word per clock, registered round-key read port.
// Optional `AES_KS_EQINV_EN adds rd_inv to read equivalent-inverse-cipher (InvMixColumns) round keys.

module aes_ks_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Leftmost byte is element 255, so the table is indexed with the complement of the input.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_o = SBOX[~in_i];
endmodule

module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    keys_valid,
  output logic                    err,
  input  logic [3:0]              rd_round,
`ifdef AES_KS_EQINV_EN
  input  logic                    rd_inv,
`endif
  output logic [127:0]            rd_key
);
  localparam int DEPTH     = (MAX_KEY_BITS >= 256) ? 60 : (MAX_KEY_BITS >= 192) ? 52 : 44;
  localparam int KEY_WORDS = MAX_KEY_BITS / 32;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state_q;
  logic [1:0]   keyLen_q;
  logic [5:0]   i_q;
  logic [2:0]   mod_q;
  logic [7:0]   rcon_q;
  logic         busy_q, keysValid_q, err_q;
  logic [127:0] rdKey_q;
  logic [31:0]  w_q [DEPTH];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [5:0] nk, total, loadNk;
  logic [3:0] nr;
  always_comb begin
    case (keyLen_q)
      2'b00:   begin nk = 6'd4; nr = 4'd10; total = 6'd44; end
      2'b01:   begin nk = 6'd6; nr = 4'd12; total = 6'd52; end
      default: begin nk = 6'd8; nr = 4'd14; total = 6'd60; end
    endcase
  end
  assign loadNk = (key_len == 2'b00) ? 6'd4 : (key_len == 2'b01) ? 6'd6 : 6'd8;

  logic illegalLen, startOk;
  assign illegalLen = (key_len == 2'b11) ||
                      (key_len == 2'b01 && MAX_KEY_BITS < 192) ||
                      (key_len == 2'b10 && MAX_KEY_BITS < 256);
  assign startOk = start && (state_q != EXPAND) && !illegalLen;

  // Schedule datapath: w[i] = w[i-Nk] ^ f(w[i-1]) with all four S-boxes shared by both transform cases.
  logic [31:0] wPrev, wBack, subIn, subOut, subTemp, wNew_d;
  assign wPrev  = w_q[i_q - 6'd1];
  assign wBack  = w_q[i_q - nk];
  assign subIn  = (mod_q == 3'd0) ? {wPrev[23:0], wPrev[31:24]} : wPrev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_ks_sbox u_sbox (.in_i(subIn[8*b +: 8]), .out_o(subOut[8*b +: 8]));
  end

  always_comb begin
    subTemp = wPrev;
    if (mod_q == 3'd0)
      subTemp = subOut ^ {rcon_q, 24'h0};
    else if (nk == 6'd8 && mod_q == 3'd4)
      subTemp = subOut;
  end
  assign wNew_d = wBack ^ subTemp;

  always_ff @(posedge clk) begin
    if (startOk) begin
      for (int k = 0; k < KEY_WORDS; k++)
        if (k < int'(loadNk)) w_q[k] <= key_in[MAX_KEY_BITS-1-32*k -: 32];
    end else if (state_q == EXPAND) begin
      w_q[i_q] <= wNew_d;
    end
  end

  // Control FSM; i mod Nk and the Rcon byte advance incrementally instead of dividing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      keyLen_q    <= 2'b00;
      i_q         <= 6'd0;
      mod_q       <= 3'd0;
      rcon_q      <= 8'h01;
      busy_q      <= 1'b0;
      keysValid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (illegalLen) begin
              err_q <= 1'b1;
            end else begin
              keyLen_q    <= key_len;
              i_q         <= loadNk;
              mod_q       <= 3'd0;
              rcon_q      <= 8'h01;
              busy_q      <= 1'b1;
              keysValid_q <= 1'b0;
              state_q     <= EXPAND;
            end
          end
        end
        EXPAND: begin
          i_q   <= i_q + 6'd1;
          mod_q <= ({3'b000, mod_q} == nk - 6'd1) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == total - 6'd1) begin
            busy_q      <= 1'b0;
            keysValid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_KS_EQINV_EN
  function automatic logic [7:0] mulC(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {mulC(a0, 4'd14) ^ mulC(a1, 4'd11) ^ mulC(a2, 4'd13) ^ mulC(a3, 4'd9),
            mulC(a0, 4'd9)  ^ mulC(a1, 4'd14) ^ mulC(a2, 4'd11) ^ mulC(a3, 4'd13),
            mulC(a0, 4'd13) ^ mulC(a1, 4'd9)  ^ mulC(a2, 4'd14) ^ mulC(a3, 4'd11),
            mulC(a0, 4'd11) ^ mulC(a1, 4'd13) ^ mulC(a2, 4'd9)  ^ mulC(a3, 4'd14)};
  endfunction
`endif

  logic [5:0]   rdBase;
  logic [127:0] fwdKey, rdKey_d;
  assign rdBase = {rd_round, 2'b00};
  assign fwdKey = {w_q[rdBase], w_q[rdBase + 6'd1], w_q[rdBase + 6'd2], w_q[rdBase + 6'd3]};

  always_comb begin
    rdKey_d = '0;
    if (keysValid_q && rd_round <= nr) begin
      rdKey_d = fwdKey;
`ifdef AES_KS_EQINV_EN
      if (rd_inv && rd_round != 4'd0 && rd_round < nr)
        rdKey_d = {invMixCol(fwdKey[127:96]), invMixCol(fwdKey[95:64]),
                   invMixCol(fwdKey[63:32]), invMixCol(fwdKey[31:0])};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdKey_q <= '0;
    else     rdKey_q <= rdKey_d;
  end

  assign busy       = busy_q;
  assign keys_valid = keysValid_q;
  assign err        = err_q;
  assign rd_key     = rdKey_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: FIPS-197 vectors plus random keys against an algebraic model.
// Build with +define+AES_KS_EQINV_EN to also exercise the equivalent-inverse read mode.

module tb_aes_key_schedule;
  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, keys_valid, err;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
`ifdef AES_KS_EQINV_EN
  logic         rd_inv;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0]  sboxM [256];
  logic [31:0] modelW [60];

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key_len(key_len),
    .key_in(key_in),
    .busy(busy),
    .keys_valid(keys_valid),
    .err(err),
    .rd_round(rd_round),
`ifdef AES_KS_EQINV_EN
    .rd_inv(rd_inv),
`endif
    .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic buildSbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxM[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] v);
    return {sboxM[v[31:24]], sboxM[v[23:16]], sboxM[v[15:8]], sboxM[v[7:0]]};
  endfunction

  task automatic buildModel(input logic [255:0] key, input int nk);
    logic [7:0]  rcon [11];
    logic [31:0] t;
    int total;
    rcon  = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) modelW[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = modelW[i-1];
      if (i % nk == 0)                t = subWord({t[23:0], t[31:24]}) ^ {rcon[i/nk], 24'h0};
      else if (nk == 8 && i % 8 == 4) t = subWord(t);
      modelW[i] = modelW[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] modelRound(input int r);
    return {modelW[4*r], modelW[4*r+1], modelW[4*r+2], modelW[4*r+3]};
  endfunction

  function automatic logic [31:0] invMixModel(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m [4][4];
    logic [31:0] res;
    m = '{'{8'd14, 8'd11, 8'd13, 8'd9}, '{8'd9, 8'd14, 8'd11, 8'd13},
          '{8'd13, 8'd9, 8'd14, 8'd11}, '{8'd11, 8'd13, 8'd9, 8'd14}};
    a = '{c[31:24], c[23:16], c[15:8], c[7:0]};
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      logic [7:0] acc;
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[r][j], a[j]);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [255:0] key, input logic [1:0] len);
    start = 1'b1; key_len = len; key_in = key;
    tick();
    start = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (keys_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic readRound(input logic [3:0] r, output logic [127:0] v);
    rd_round = r;
    tick();
    v = rd_key;
  endtask

  function automatic logic [255:0] randKey;
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (keys_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", keys_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (rd_key !== 128'h0) begin errors++; $display("[TB] FAIL reset_rdkey: got %h expected 0", rd_key); end
    rst = 1'b0;
    tick();
    checks++; if (rd_key !== 128'h0) begin errors++; $display("[TB] FAIL idle_rdkey: got %h expected 0", rd_key); end
  endtask

  task automatic test_known(input logic [255:0] key, input logic [1:0] len, input logic [127:0] lastKey);
    int n, nk, nr;
    logic [127:0] v;
    nk = 4 + 2 * int'(len); nr = nk + 6;
    doStart(key, len);
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("[TB] FAIL known_busy: got busy=%b err=%b expected 1/0", busy, err); end
    waitValid(n);
    checks++; if (n != 4 * (nr + 1) - nk) begin errors++; $display("[TB] FAIL known_latency: got %0d expected %0d", n, 4 * (nr + 1) - nk); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL known_busy_done: got %b expected 0", busy); end
    readRound(4'(nr), v);
    checks++; if (v !== lastKey) begin errors++; $display("[TB] FAIL known_last_round: got %h expected %h", v, lastKey); end
    readRound(4'd0, v);
    checks++; if (v !== key[255:128]) begin errors++; $display("[TB] FAIL known_round0: got %h expected %h", v, key[255:128]); end
    readRound(4'(nr + 1), v);
    checks++; if (v !== 128'h0) begin errors++; $display("[TB] FAIL known_beyond_nr: got %h expected 0", v); end
  endtask

  task automatic test_random;
    int n, nk, nr;
    logic [255:0] key;
    logic [127:0] v;
    for (int len = 0; len < 3; len++) begin
      for (int rep = 0; rep < 2; rep++) begin
        nk = 4 + 2 * len; nr = nk + 6;
        key = randKey();
        buildModel(key, nk);
        doStart(key, 2'(len));
        waitValid(n);
        checks++; if (n != 4 * (nr + 1) - nk) begin errors++; $display("[TB] FAIL rand_latency: got %0d expected %0d", n, 4 * (nr + 1) - nk); end
        for (int r = 0; r <= nr + 1; r++) begin
          readRound(4'(r), v);
          checks++;
          if (v !== ((r <= nr) ? modelRound(r) : 128'h0)) begin
            errors++;
            $display("[TB] FAIL rand_round len=%0d r=%0d: got %h expected %h", len, r, v, (r <= nr) ? modelRound(r) : 128'h0);
          end
        end
      end
    end
  endtask

  task automatic test_illegal;
    int n;
    logic [255:0] key;
    logic [127:0] v;
    key = randKey();
    buildModel(key, 4);
    doStart(key, 2'b00);
    waitValid(n);
    doStart(randKey(), 2'b11);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_pulse: got %b expected 1", err); end
    checks++; if (keys_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL illegal_state: got valid=%b busy=%b expected 1/0", keys_valid, busy); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_clear: got %b expected 0", err); end
    readRound(4'd7, v);
    checks++; if (v !== modelRound(7)) begin errors++; $display("[TB] FAIL illegal_keys_kept: got %h expected %h", v, modelRound(7)); end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [255:0] keyA;
    logic [127:0] v;
    keyA = randKey();
    buildModel(keyA, 6);
    doStart(keyA, 2'b01);
    repeat (9) tick();
    doStart(randKey(), 2'b00);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL expand_start_err: got %b expected 0", err); end
    doStart(randKey(), 2'b11);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL expand_illegal_err: got %b expected 0", err); end
    waitValid(n);
    checks++; if (n != 46 - 11) begin errors++; $display("[TB] FAIL expand_latency: got %0d expected %0d", n, 35); end
    for (int r = 0; r <= 12; r += 4) begin
      readRound(4'(r), v);
      checks++; if (v !== modelRound(r)) begin errors++; $display("[TB] FAIL expand_ignored r=%0d: got %h expected %h", r, v, modelRound(r)); end
    end
  endtask

  task automatic test_rst_mid;
    int n;
    logic [127:0] v;
    doStart({randKey()}, 2'b00);
    repeat (17) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || keys_valid !== 1'b0 || rd_key !== 128'h0) begin
      errors++; $display("[TB] FAIL rstmid_abort: got busy=%b valid=%b rd_key=%h expected 0/0/0", busy, keys_valid, rd_key);
    end
    tick();
    rst = 1'b0;
    doStart({128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef}, 2'b00);
    waitValid(n);
    checks++; if (n != 40) begin errors++; $display("[TB] FAIL rstmid_latency: got %0d expected 40", n); end
    readRound(4'd10, v);
    checks++; if (v !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin errors++; $display("[TB] FAIL rstmid_round10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", v); end
  endtask

`ifdef AES_KS_EQINV_EN
  task automatic test_eqinv;
    int n;
    logic [255:0] key;
    logic [127:0] v, exp5;
    key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdef};
    buildModel(key, 4);
    doStart(key, 2'b00);
    waitValid(n);
    rd_inv = 1'b1;
    readRound(4'd0, v);
    checks++; if (v !== modelRound(0)) begin errors++; $display("[TB] FAIL eqinv_round0: got %h expected %h", v, modelRound(0)); end
    readRound(4'd10, v);
    checks++; if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin errors++; $display("[TB] FAIL eqinv_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", v); end
    exp5 = {invMixModel(modelW[20]), invMixModel(modelW[21]), invMixModel(modelW[22]), invMixModel(modelW[23])};
    readRound(4'd5, v);
    checks++; if (v !== exp5) begin errors++; $display("[TB] FAIL eqinv_round5: got %h expected %h", v, exp5); end
    rd_inv = 1'b0;
    readRound(4'd5, v);
    checks++; if (v !== modelRound(5)) begin errors++; $display("[TB] FAIL eqinv_fwd_round5: got %h expected %h", v, modelRound(5)); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0; rd_round = 4'd0;
`ifdef AES_KS_EQINV_EN
    rd_inv = 1'b0;
`endif
    buildSbox();
    test_reset();
    test_known({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hffffffffffffffffffffffffffffffff}, 2'b00,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_known({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'ha5a5a5a5a5a5a5a5}, 2'b01,
               128'he98ba06f448c773c8ecc720401002202);
    test_known(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b10,
               128'hfe4890d1e6188d0b046df344706c631e);
    test_random();
    test_illegal();
    test_back_to_back();
    test_rst_mid();
`ifdef AES_KS_EQINV_EN
    test_eqinv();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative AES key schedule for 128/192/256-bit keys, selected per operation by `key_len`. It generates one 32-bit schedule word per clock into an internal round-key store of up to 60 words. Once expansion finishes, round keys 0..Nr are read through a registered read port. It is the sequential, multi-key-size successor to the single-step combinational AES-128 round-key generator, and feeds the round datapath of the AES core.

Parameters:
- MAX_KEY_BITS, 256, largest supported key (128, 192 or 256); sets the `key_in` width and the store depth (44/52/60 words).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle request to load `key_in` and begin expansion
- key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
- key_in  input  MAX_KEY_BITS  cipher key, MSB-aligned; unused LSBs ignored
- busy  output  1  expansion in progress
- keys_valid  output  1  store holds a complete schedule for the latched key_len
- err  output  1  one-cycle pulse: illegal or unsupported key_len at start
- rd_round  input  4  round-key index 0..Nr
- rd_key  output  128  round key rd_round = {w[4r], w[4r+1], w[4r+2], w[4r+3]}

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, keys_valid=0, err=0, rd_key=0, word counter=0.
  - Store contents are don't-care; outputs are gated by keys_valid.
  - rst asserted mid-expansion aborts immediately; the next start begins a fresh expansion.
- Per key_len: Nk=4/6/8, Nr=10/12/14, Total=4*(Nr+1)=44/52/60.
- States: IDLE, EXPAND, DONE.
- start sampled at edge T while in IDLE or DONE, with legal key_len (key_len=11, or key bits > MAX_KEY_BITS, is unsupported):
  - Latch key_len.
  - Write w[0..Nk-1] from key_in (w[0] = MSBs).
  - Set i=Nk, keys_valid=0, busy=1, go to EXPAND.
- start with illegal or unsupported key_len:
  - err=1 for one cycle.
  - State, keys_valid and store are unchanged.
- start while in EXPAND: ignored; no err.
- EXPAND, one word per edge:
  - temp = w[i-1].
  - If i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
  - Else if Nk=8 and i mod 8 = 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; then i++.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 for indices 1..10.
  - On the edge that writes w[Total-1]: busy=0, keys_valid=1, go to DONE.
- Latency: keys_valid is high after Total-Nk edges following T: 40 (128), 46 (192), 52 (256).
- i mod Nk and i/Nk are tracked with incremental counters, not dividers.
- SubWord: 4 S-box instances, all on the single per-cycle path.
- Read port:
  - rd_key is registered, 1-cycle latency from rd_round.
  - rd_key=0 if keys_valid=0 or rd_round > Nr.
  - Reads are legal in DONE at any rate.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: AES_KS_EQINV_EN.
- Defined:
  - Adds input port rd_inv (1 bit).
  - When rd_inv=1 and 1 <= rd_round <= Nr-1, rd_key returns InvMixColumns applied to each of the four words (equivalent inverse cipher key).
  - Rounds 0 and Nr are returned untransformed.
  - Latency stays 1 cycle.
- Not defined: no rd_inv port; rd_key is always the forward round key.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid rises exactly 40 edges after start; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 next cycle; rd_round=0 returns the key.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> keys_valid after 46 edges; rd_round=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> keys_valid after 52 edges; rd_round=14 gives fe4890d1e6188d0b046df344706c631e; rd_round=15 gives 0.
- key_len=11 in DONE -> err pulses one cycle; keys_valid stays 1; previous keys still readable. Second start during EXPAND -> ignored; result matches the first key.
- rst pulsed at word 20 of an AES-128 run -> busy=0, keys_valid=0, rd_key=0. Restart with key 000102030405060708090a0b0c0d0e0f -> round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- AES_KS_EQINV_EN defined: AES-128 run (key 2b7e...4f3c), rd_inv=1 -> rounds 0 and 10 match the forward keys; round 5 equals software InvMixColumns of forward round 5.
